// File: rtl/mrd_source_seq_pn_if.sv
// Bus bundle between the source-stage sequencer, the top FSM and the
// RAM/datapath it feeds. The sequencer sits on the slave side.
interface mrd_source_seq_pn_if #(
   parameter int NLANE = 4,
   parameter int WPTS  = 12
);
   logic [2:0]                   fsm;
   logic [WPTS-1:0]              dftpts;
   logic                         stride_mode;
   logic                         out_ready;
   logic [NLANE-1:0][WPTS-1:0]   addrs;
   logic                         addr_valid;
   logic [NLANE-1:0]             addr_mask;
   logic                         pipe_en;
   logic                         out_sop;
   logic                         out_eop;
   logic                         out_valid;
   logic [NLANE-1:0]             out_mask;
   logic                         valid_out_pre;
   logic                         source_end;

   modport master (
      output fsm, dftpts, stride_mode, out_ready,
      input  addrs, addr_valid, addr_mask, pipe_en, out_sop, out_eop,
             out_valid, out_mask, valid_out_pre, source_end
   );

   modport slave (
      input  fsm, dftpts, stride_mode, out_ready,
      output addrs, addr_valid, addr_mask, pipe_en, out_sop, out_eop,
             out_valid, out_mask, valid_out_pre, source_end
   );
endinterface

// File: rtl/mrd_source_seq_pn.sv
// Source-stage sequencer for the mixed-radix DFT memory path.
// While the top FSM sits in Source it issues NLANE bank read addresses per
// beat (natural or strided order) and carries a framing token through an
// RD_LAT delay line so sop/eop/valid/mask line up with the RAM read data.
// Downstream backpressure stalls the whole pipe through pipe_en; leaving
// Source early flushes everything without a completion pulse.
module mrd_source_seq_pn #(
   parameter int NLANE  = 4,
   parameter int WPTS   = 12,
   parameter int WAIT   = 4,
   parameter int RD_LAT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   mrd_source_seq_pn_if.slave bus
);

   localparam int              LG         = $clog2(NLANE);
   localparam logic [2:0]      FSM_SOURCE = 3'd5;
   localparam logic [3:0]      WAIT_LAST  = 4'(WAIT);
   localparam logic [WPTS-1:0] LANE_BITS  = WPTS'(NLANE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             sop;
      logic             eop;
      logic [NLANE-1:0] mask;
   } token_t;

   state_t state;
   state_t state_nxt;

   // Frame parameters captured on Source entry
   logic [WPTS-1:0] pts_q;
   logic [WPTS-1:0] beats_q;
   logic [WPTS-1:0] quot_q;
   logic            stride_q;

   // Progress counters
   logic [3:0]      wait_cnt;
   logic [WPTS-1:0] beat_cnt;

   // Framing delay line; the highest index is the output stage
   token_t [RD_LAT-1:0] dline;
   token_t              tok_in;

   logic source_end_q;

   // Decoded control
   logic            in_source;
   logic            entry;
   logic            leave;
   logic            wait_done;
   logic            last_beat;
   logic            eop_accept;
   logic            pipe_en;
   logic [WPTS-1:0] quot_in;
   logic [WPTS-1:0] beats_in;
   logic [WPTS:0]   nat_base;

   // Address stage outputs
   logic                       addr_valid;
   logic                       sop_tok;
   logic                       eop_tok;
   logic [NLANE-1:0]           addr_mask;
   logic [NLANE-1:0][WPTS-1:0] addrs;
   logic [WPTS:0]              lane_idx;

   assign in_source  = (bus.fsm == FSM_SOURCE);
   assign entry      = (state == S_IDLE) && in_source;
   assign leave      = (state != S_IDLE) && !in_source;
   assign wait_done  = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
   assign last_beat  = (beat_cnt == (beats_q - WPTS'(1)));

   // The output stage is empty or being accepted: the pipe may move.
   assign pipe_en    = bus.out_ready | ~dline[RD_LAT-1].valid;
   assign eop_accept = dline[RD_LAT-1].valid & dline[RD_LAT-1].eop & bus.out_ready;

   // Beat count rounds up so a partial last beat still gets issued; the
   // remainder test avoids overflowing dftpts + NLANE - 1 in WPTS bits.
   assign quot_in    = bus.dftpts >> LG;
   assign beats_in   = quot_in + WPTS'(|(bus.dftpts & LANE_BITS));
   assign nat_base   = {1'b0, beat_cnt} << LG;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; leaving Source in any active state is an abort
   always_comb begin
      state_nxt = state;
      if (leave) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_source) begin
                  state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_done) begin
                  state_nxt = (beats_q == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (pipe_en && last_beat) begin
                  state_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (eop_accept) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE: begin
               state_nxt = S_DONE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Address-stage outputs: current beat's lane addresses, mask and framing
   always_comb begin
      addr_valid = (state == S_ISSUE);
      sop_tok    = addr_valid && (beat_cnt == '0);
      eop_tok    = addr_valid && last_beat;
      addr_mask  = '0;
      addrs      = '0;
      lane_idx   = '0;
      for (int i = 0; i < NLANE; i++) begin
         lane_idx = nat_base + (WPTS+1)'(i);
         if (addr_valid && (lane_idx < {1'b0, pts_q})) begin
            addr_mask[i] = 1'b1;
            addrs[i]     = stride_q ? (beat_cnt + (WPTS'(i) * quot_q))
                                    : lane_idx[WPTS-1:0];
         end
      end
   end

   // Frame capture and counters; the wait counter runs freely, the beat
   // counter only moves when the pipe accepts the current beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pts_q    <= '0;
         beats_q  <= '0;
         quot_q   <= '0;
         stride_q <= 1'b0;
         wait_cnt <= '0;
         beat_cnt <= '0;
      end else if (leave) begin
         pts_q    <= '0;
         beats_q  <= '0;
         quot_q   <= '0;
         stride_q <= 1'b0;
         wait_cnt <= '0;
         beat_cnt <= '0;
      end else begin
         if (entry) begin
            pts_q    <= bus.dftpts;
            beats_q  <= beats_in;
            quot_q   <= quot_in;
            stride_q <= bus.stride_mode;
            wait_cnt <= '0;
            beat_cnt <= '0;
         end
         if ((state == S_WAIT) && !wait_done) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         if ((state == S_ISSUE) && pipe_en) begin
            beat_cnt <= last_beat ? '0 : (beat_cnt + WPTS'(1));
         end
      end
   end

   assign tok_in = {addr_valid, sop_tok, eop_tok, addr_mask};

   // Framing delay line, shifted together with the RAM/datapath pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dline <= '0;
      end else if (leave) begin
         dline <= '0;
      end else if (pipe_en) begin
         dline <= {dline[RD_LAT-2:0], tok_in};
      end
   end

   // Completion pulse: after the eop beat is taken, or straight out of the
   // wait phase for an empty frame; an abort suppresses it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         source_end_q <= 1'b0;
      end else begin
         source_end_q <= !leave &&
                         (((state == S_DRAIN) && eop_accept) ||
                          (wait_done && (beats_q == '0)));
      end
   end

   assign bus.addrs         = addrs;
   assign bus.addr_valid    = addr_valid;
   assign bus.addr_mask     = addr_mask;
   assign bus.pipe_en       = pipe_en;
   assign bus.out_valid     = dline[RD_LAT-1].valid;
   assign bus.out_sop       = dline[RD_LAT-1].sop;
   assign bus.out_eop       = dline[RD_LAT-1].eop;
   assign bus.out_mask      = dline[RD_LAT-1].mask;
   assign bus.valid_out_pre = dline[RD_LAT-2].valid;
   assign bus.source_end    = source_end_q;

endmodule

// File: tb/tb_mrd_source_seq_pn.sv
// Self-checking bench for the source-stage sequencer: directed frames from
// the test plan followed by random frames with random backpressure, checked
// against an expected-beat list built from the addressing rules.
module tb_mrd_source_seq_pn;

   localparam int NLANE  = 4;
   localparam int WPTS   = 12;
   localparam int WAITC  = 4;
   localparam int RD_LAT = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [NLANE-1:0][WPTS-1:0] addrs;
      logic [NLANE-1:0]           mask;
      logic                       sop;
      logic                       eop;
   } beat_t;

   beat_t exp_addr_q[$];
   beat_t exp_out_q[$];

   // Free-running clock
   always #5 clk = ~clk;

   mrd_source_seq_pn_if #(.NLANE(NLANE), .WPTS(WPTS)) bus ();

   mrd_source_seq_pn #(
      .NLANE (NLANE),
      .WPTS  (WPTS),
      .WAIT  (WAITC),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [63:0] allOutputs();
      return 64'({bus.addr_valid, bus.addrs, bus.addr_mask, bus.out_sop, bus.out_eop,
                  bus.out_valid, bus.out_mask, bus.valid_out_pre, bus.source_end});
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected beats straight from the addressing rules
   task automatic buildFrame(input int pts, input bit str);
      int    nb;
      int    q;
      int    idx;
      beat_t bt;
      nb = (pts + NLANE - 1) / NLANE;
      q  = pts / NLANE;
      exp_addr_q.delete();
      exp_out_q.delete();
      for (int b = 0; b < nb; b++) begin
         bt.addrs = '0;
         bt.mask  = '0;
         for (int i = 0; i < NLANE; i++) begin
            idx = b * NLANE + i;
            if (idx < pts) begin
               bt.mask[i]  = 1'b1;
               bt.addrs[i] = WPTS'(str ? (b + i * q) : idx);
            end
         end
         bt.sop = (b == 0);
         bt.eop = (b == nb - 1);
         exp_addr_q.push_back(bt);
         exp_out_q.push_back(bt);
      end
   endtask

   // One Source frame. mode 0: always ready, 1: ready low in a window,
   // 2: random ready. abort_at >= 0 drops fsm in that cycle.
   task automatic applyStimulus(input int pts, input bit str, input int mode,
                                input int stall_at, input int stall_len, input int abort_at);
      int    nb;
      int    budget;
      int    eop_cycle;
      int    se_cycle;
      int    acc_cnt;
      int    se_nostall;
      bit    done_seen;
      bit    finished;
      logic  rdy;
      beat_t f;

      nb         = (pts + NLANE - 1) / NLANE;
      se_nostall = (nb == 0) ? (WAITC + 1) : (WAITC + nb + RD_LAT + 1);
      budget     = 4 * nb + WAITC + RD_LAT + 40 + stall_len;
      eop_cycle  = -1;
      se_cycle   = -1;
      acc_cnt    = 0;
      done_seen  = 1'b0;
      finished   = 1'b0;
      buildFrame(pts, str);
      $display("[TB] frame dftpts=%0d stride=%0d mode=%0d abort_at=%0d", pts, str, mode, abort_at);

      @(posedge clk);
      #1;
      bus.dftpts      = WPTS'(pts);
      bus.stride_mode = str;
      bus.out_ready   = 1'b1;
      bus.fsm         = 3'd5;

      for (int c = 0; c < budget && !finished; c++) begin
         @(posedge clk);
         #1;
         bus.fsm = (abort_at >= 0 && c >= abort_at) ? 3'd0 : 3'd5;
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = !(c >= stall_at && c < stall_at + stall_len);
         else rdy = ($urandom_range(0, 3) != 0);
         bus.out_ready = rdy;
         #1;

         if (abort_at >= 0 && c > abort_at) begin
            checkOutput("abort_outputs_zero", allOutputs(), 64'd0);
            if (c >= abort_at + RD_LAT + 4) finished = 1'b1;
         end else begin
            if (mode == 0) begin
               checkOutput("t_addr_valid", 64'(bus.addr_valid),
                           64'(c >= WAITC + 1 && c <= WAITC + nb));
               checkOutput("t_out_valid", 64'(bus.out_valid),
                           64'(c >= WAITC + 1 + RD_LAT && c <= WAITC + nb + RD_LAT));
               checkOutput("t_valid_out_pre", 64'(bus.valid_out_pre),
                           64'(c >= WAITC + RD_LAT && c <= WAITC + nb + RD_LAT - 1));
               checkOutput("t_out_sop", 64'(bus.out_sop),
                           64'(nb > 0 && c == WAITC + 1 + RD_LAT));
               checkOutput("t_out_eop", 64'(bus.out_eop),
                           64'(nb > 0 && c == WAITC + nb + RD_LAT));
               checkOutput("t_source_end", 64'(bus.source_end),
                           64'(abort_at < 0 && c == se_nostall));
               checkOutput("t_pipe_en", 64'(bus.pipe_en), 64'd1);
            end
            if (mode == 1 && c >= stall_at && c < stall_at + stall_len) begin
               checkOutput("stall_pipe_en", 64'(bus.pipe_en), 64'd0);
            end

            if (bus.addr_valid) begin
               if (exp_addr_q.size() == 0) begin
                  checkOutput("addr_extra_beat", 64'd1, 64'd0);
               end else begin
                  f = exp_addr_q[0];
                  checkOutput("addrs", 64'(bus.addrs), 64'(f.addrs));
                  checkOutput("addr_mask", 64'(bus.addr_mask), 64'(f.mask));
                  if (bus.pipe_en) void'(exp_addr_q.pop_front());
               end
            end

            if (bus.out_valid) begin
               if (exp_out_q.size() == 0) begin
                  checkOutput("out_extra_beat", 64'd1, 64'd0);
               end else begin
                  f = exp_out_q[0];
                  checkOutput("out_beat", 64'({bus.out_sop, bus.out_eop, bus.out_mask}),
                              64'({f.sop, f.eop, f.mask}));
                  if (bus.out_ready) begin
                     void'(exp_out_q.pop_front());
                     acc_cnt++;
                     if (f.eop) eop_cycle = c;
                  end
               end
            end

            if (bus.source_end && !done_seen) begin
               checkOutput("source_end_cycle", 64'(c),
                           64'((nb == 0) ? (WAITC + 1) : (eop_cycle + 1)));
               if (mode == 1) begin
                  checkOutput("stall_source_end_cycle", 64'(c), 64'(se_nostall + stall_len));
               end
               done_seen = 1'b1;
               se_cycle  = c;
            end else if (done_seen && c == se_cycle + 1) begin
               checkOutput("source_end_pulse", 64'(bus.source_end), 64'd0);
               finished = 1'b1;
            end
         end
      end

      if (abort_at < 0) begin
         if (!done_seen) checkOutput("source_end_timeout", 64'd0, 64'd1);
         checkOutput("beats_accepted", 64'(acc_cnt), 64'(nb));
         checkOutput("addr_beats_left", 64'(exp_addr_q.size()), 64'd0);
      end else if (!finished) begin
         checkOutput("abort_timeout", 64'd0, 64'd1);
      end

      @(posedge clk);
      #1;
      bus.fsm       = 3'd0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // Directed plan, then random frames
   initial begin
      int pts;
      bit str;

      bus.fsm         = 3'd0;
      bus.dftpts      = '0;
      bus.stride_mode = 1'b0;
      bus.out_ready   = 1'b1;
      rst_n           = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", allOutputs(), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_outputs", allOutputs(), 64'd0);

      applyStimulus(12,   1'b0, 0, 0, 0, -1);
      applyStimulus(1202, 1'b0, 0, 0, 0, -1);
      applyStimulus(48,   1'b1, 0, 0, 0, -1);
      applyStimulus(16,   1'b0, 1, WAITC + 1 + RD_LAT, 3, -1);
      applyStimulus(64,   1'b0, 0, 0, 0, 9);
      applyStimulus(64,   1'b0, 0, 0, 0, -1);
      applyStimulus(0,    1'b0, 0, 0, 0, -1);

      $display("[TB] async reset during issue");
      bus.dftpts      = WPTS'(64);
      bus.stride_mode = 1'b0;
      @(posedge clk);
      #1;
      bus.fsm = 3'd5;
      repeat (7) @(posedge clk);
      #2;
      checkOutput("pre_reset_addr_valid", 64'(bus.addr_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", allOutputs(), 64'd0);
      bus.fsm = 3'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int k = 0; k < 8; k++) begin
         str = 1'($urandom_range(0, 1));
         pts = str ? NLANE * int'($urandom_range(0, 30)) : int'($urandom_range(0, 150));
         applyStimulus(pts, str, 2, 0, 0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
